// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the register-address type.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_decoder5_32.sv
// 5-to-32 one-hot decoder with enable; drives the per-register write enables.
module DECODER5_32
    import mips_pkg::*;
(
    input  reg_addr_t             i_addr,
    input  logic                  i_en,
    output logic [NUM_REGS-1:0]   o_onehot
);

    // Gating every bit by i_en keeps an unknown address harmless while disabled.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_onehot[i] = i_en && (i_addr == reg_addr_t'(i));
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32-entry MIPS register file: two combinational read ports, $0 hard-wired to zero,
// optional same-cycle write bypass and sticky per-register written flags.
module reg_file
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_write,
    input  reg_addr_t            write_reg,
    input  logic [WIDTH-1:0]     write_data,
    input  reg_addr_t            read_reg1,
    input  reg_addr_t            read_reg2,
    output logic [WIDTH-1:0]     read_data1,
    output logic [WIDTH-1:0]     read_data2,
    output logic [NUM_REGS-1:0]  written
);

    localparam logic [NUM_REGS-1:0] ZeroMask = NUM_REGS'(1);

    logic [NUM_REGS-1:0] w_we;
    logic [WIDTH-1:0]    r_regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] r_written;
    logic                w_byp1;
    logic                w_byp2;

    DECODER5_32 u_dec (
        .i_addr   (write_reg),
        .i_en     (reg_write),
        .o_onehot (w_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_written <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= write_data;
                end
            end
            // Bit 0 is masked so writes to $0 never mark it.
            r_written <= r_written | (w_we & ~ZeroMask);
        end
    end

    assign w_byp1 = BYPASS && reg_write && (write_reg != REG_ZERO) && (read_reg1 == write_reg);
    assign w_byp2 = BYPASS && reg_write && (write_reg != REG_ZERO) && (read_reg2 == write_reg);

    always_comb begin
        read_data1 = '0;
        if (w_byp1) begin
            read_data1 = write_data;
        end else if (read_reg1 != REG_ZERO) begin
            read_data1 = r_regs[read_reg1];
        end
    end

    always_comb begin
        read_data2 = '0;
        if (w_byp2) begin
            read_data2 = write_data;
        end else if (read_reg2 != REG_ZERO) begin
            read_data2 = r_regs[read_reg2];
        end
    end

    assign written = r_written;

endmodule
